// File: rtl/sys_defs.sv
// Shared definitions for the superscalar front end.
//   XLEN           : instruction / PC width
//   NOP            : encoding driven on instruction slots that carry no valid op
//   INST_BUF_ENTRY : one instruction-buffer storage entry {inst, pc}
package sys_defs;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } INST_BUF_ENTRY;

endpackage

// File: rtl/inst_buffer_ptr_calc.sv
// Combinational pointer/occupancy arithmetic for the instruction buffer.
//   head, tail       : registered read / write pointers
//   count            : registered occupancy
//   if_valid         : per-slot fetch valid (slot 0 oldest)
//   rollback         : number of youngest presented slots to keep for replay
//   squash           : flush; forces next state to empty
//   if_ready         : buffer can accept a full 3-wide group this cycle
//   n_enq/n_pres/n_deq : enqueued, presented and consumed slot counts
//   head_d/tail_d/count_d : next-state pointer and occupancy values
module inst_buffer_ptr_calc #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  input  logic [CNT_W-1:0] count,
  input  logic [2:0]       if_valid,
  input  logic [1:0]       rollback,
  input  logic             squash,
  output logic             if_ready,
  output logic [1:0]       n_enq,
  output logic [1:0]       n_pres,
  output logic [1:0]       n_deq,
  output logic [PTR_W-1:0] head_d,
  output logic [PTR_W-1:0] tail_d,
  output logic [CNT_W-1:0] count_d
);

  // Readiness depends on registered occupancy only, so a dequeue happening
  // this cycle never opens the door for a same-cycle enqueue.
  assign if_ready = (count <= CNT_W'(DEPTH - 3));

  always_comb begin
    n_enq   = 2'd0;
    n_pres  = 2'd0;
    n_deq   = 2'd0;
    head_d  = head;
    tail_d  = tail;
    count_d = count;

    // Only the contiguous run of valid slots starting at slot 0 is taken;
    // anything after a gap is refetched later.
    if (if_ready) begin
      if (if_valid[0]) begin
        if (if_valid[1]) n_enq = if_valid[2] ? 2'd3 : 2'd2;
        else             n_enq = 2'd1;
      end
    end

    n_pres = (count >= CNT_W'(3)) ? 2'd3 : count[1:0];

    // Rollback larger than what is presented simply consumes nothing.
    n_deq = (n_pres > rollback) ? (n_pres - rollback) : 2'd0;

    // DEPTH is a power of two, so plain truncating adds wrap the pointers.
    head_d  = head + PTR_W'(n_deq);
    tail_d  = tail + PTR_W'(n_enq);
    count_d = count + CNT_W'(n_enq) - CNT_W'(n_deq);

    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// 3-wide circular instruction buffer between IF and ID.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low clear of pointers and occupancy
//   if_valid/if_inst/if_pc : up to three fetched instructions, slot 0 oldest
//   if_ready : buffer can take a full 3-wide group this cycle
//   rollback : youngest presented valid slots to replay next cycle (0..3)
//   squash   : empties the buffer at the next edge, discarding same-cycle traffic
//   id_valid/id_inst/id_pc : oldest three entries presented to decode
//   count    : current occupancy
module inst_buffer
  import sys_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = sys_defs::XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 if_valid,
  input  logic [2:0][XLEN-1:0]       if_inst,
  input  logic [2:0][XLEN-1:0]       if_pc,
  output logic                       if_ready,
  input  logic [1:0]                 rollback,
  input  logic                       squash,
  output logic [2:0]                 id_valid,
  output logic [2:0][XLEN-1:0]       id_inst,
  output logic [2:0][XLEN-1:0]       id_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0] n_enq, n_pres, n_deq;

  // Storage has no reset: entries beyond the occupied window are never shown.
  INST_BUF_ENTRY mem_q [DEPTH];

  logic [2:0]            wr_en;
  logic [2:0][PTR_W-1:0] wr_idx;
  logic [2:0][PTR_W-1:0] rd_idx;
  INST_BUF_ENTRY         wr_entry [3];

  inst_buffer_ptr_calc #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr_calc (
    .head     (head_q),
    .tail     (tail_q),
    .count    (count_q),
    .if_valid (if_valid),
    .rollback (rollback),
    .squash   (squash),
    .if_ready (if_ready),
    .n_enq    (n_enq),
    .n_pres   (n_pres),
    .n_deq    (n_deq),
    .head_d   (head_d),
    .tail_d   (tail_d),
    .count_d  (count_d)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      // Write side: slot gi lands at tail+gi when it is part of the accepted run.
      assign wr_en[gi]          = !squash && (n_enq > 2'(gi));
      assign wr_idx[gi]         = tail_q + PTR_W'(gi);
      assign wr_entry[gi].inst  = if_inst[gi];
      assign wr_entry[gi].pc    = if_pc[gi];

      // Read side: presentation is purely from registered state, so a freshly
      // written entry is first visible the cycle after it is written.
      assign rd_idx[gi]   = head_q + PTR_W'(gi);
      assign id_valid[gi] = (n_pres > 2'(gi));
      assign id_inst[gi]  = id_valid[gi] ? mem_q[rd_idx[gi]].inst : NOP;
      assign id_pc[gi]    = id_valid[gi] ? mem_q[rd_idx[gi]].pc   : '0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= wr_entry[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  localparam logic [31:0] NOP_W = 32'h00000013;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        if_valid = '0;
  logic [2:0][31:0]  if_inst  = '0;
  logic [2:0][31:0]  if_pc    = '0;
  logic              if_ready;
  logic [1:0]        rollback = '0;
  logic              squash   = 1'b0;
  logic [2:0]        id_valid;
  logic [2:0][31:0]  id_inst;
  logic [2:0][31:0]  id_pc;
  logic [3:0]        count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  inst_buffer #(.DEPTH(8), .XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .rollback (rollback),
    .squash   (squash),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc    (id_pc),
    .count    (count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a fetch group of consecutive PCs starting at base.
  task automatic set_group(input logic [31:0] base, input logic [2:0] v);
    if_valid = v;
    for (int i = 0; i < 3; i++) begin
      if_pc[i]   = base + 32'(4 * i);
      if_inst[i] = 32'hA000_0000 | (base + 32'(4 * i));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    total_cnt++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b000) $display("FAIL reset_id_valid: got %b expected 000", id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready: got %b expected 1", if_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (id_inst[i] !== NOP_W) $display("FAIL reset_id_inst%0d: got %h expected %h", i, id_inst[i], NOP_W); else pass_cnt++;
      total_cnt++; if (id_pc[i] !== 32'h0) $display("FAIL reset_id_pc%0d: got %h expected 0", i, id_pc[i]); else pass_cnt++;
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    $display("reset: count=%0d id_valid=%b if_ready=%b", count, id_valid, if_ready);
  endtask

  task automatic test_fill();
    rollback = 2'd3;
    set_group(32'h0, 3'b111);
    step();
    total_cnt++; if (count !== 4'd3) $display("FAIL fill1_count: got %0d expected 3", count); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL fill1_if_ready: got %b expected 1", if_ready); else pass_cnt++;
    $display("fill group 0x0: count=%0d if_ready=%b", count, if_ready);
    set_group(32'hC, 3'b111);
    step();
    total_cnt++; if (count !== 4'd6) $display("FAIL fill2_count: got %0d expected 6", count); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL fill2_if_ready: got %b expected 0", if_ready); else pass_cnt++;
    $display("fill group 0xC: count=%0d if_ready=%b", count, if_ready);
    set_group(32'h18, 3'b111);
    step();
    total_cnt++; if (count !== 4'd6) $display("FAIL fill3_held_count: got %0d expected 6", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b111) $display("FAIL fill3_id_valid: got %b expected 111", id_valid); else pass_cnt++;
    total_cnt++; if (id_pc !== {32'h8, 32'h4, 32'h0}) $display("FAIL fill3_id_pc: got %h expected 8,4,0", id_pc); else pass_cnt++;
    total_cnt++; if (id_inst[1] !== 32'hA000_0004) $display("FAIL fill3_id_inst1: got %h expected a0000004", id_inst[1]); else pass_cnt++;
    $display("fill group 0x18 held: count=%0d id_pc=%h", count, id_pc);
  endtask

  task automatic test_partial_rollback();
    if_valid = 3'b000;
    rollback = 2'd1;
    step();
    total_cnt++; if (count !== 4'd4) $display("FAIL rb1_count: got %0d expected 4", count); else pass_cnt++;
    total_cnt++; if (id_pc !== {32'h10, 32'hC, 32'h8}) $display("FAIL rb1_id_pc: got %h expected 10,c,8", id_pc); else pass_cnt++;
    $display("rollback=1: count=%0d id_pc=%h", count, id_pc);
    rollback = 2'd2;
    step();
    total_cnt++; if (count !== 4'd3) $display("FAIL rb2_count: got %0d expected 3", count); else pass_cnt++;
    total_cnt++; if (id_pc !== {32'h14, 32'h10, 32'hC}) $display("FAIL rb2_id_pc: got %h expected 14,10,c", id_pc); else pass_cnt++;
    $display("rollback=2: count=%0d id_pc=%h", count, id_pc);
  endtask

  task automatic test_rollback_sat();
    rollback = 2'd2;
    step();
    total_cnt++; if (count !== 4'd2) $display("FAIL sat_pre_count: got %0d expected 2", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b011) $display("FAIL sat_pre_id_valid: got %b expected 011", id_valid); else pass_cnt++;
    rollback = 2'd3;
    step();
    total_cnt++; if (count !== 4'd2) $display("FAIL sat_count: got %0d expected 2", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b011) $display("FAIL sat_id_valid: got %b expected 011", id_valid); else pass_cnt++;
    total_cnt++; if (id_pc !== {32'h0, 32'h14, 32'h10}) $display("FAIL sat_id_pc: got %h expected 0,14,10", id_pc); else pass_cnt++;
    total_cnt++; if (id_inst[2] !== NOP_W) $display("FAIL sat_id_inst2: got %h expected %h", id_inst[2], NOP_W); else pass_cnt++;
    $display("rollback=3 with 2 presented: count=%0d id_valid=%b id_pc=%h", count, id_valid, id_pc);
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    logic [31:0] exp_pc;
    squash   = 1'b1;
    rollback = 2'd0;
    if_valid = 3'b000;
    step();
    squash = 1'b0;
    total_cnt++; if (count !== 4'd0) $display("FAIL wrap_clear_count: got %0d expected 0", count); else pass_cnt++;
    pc     = 32'h100;
    exp_pc = 32'h100;
    for (int c = 0; c < 20; c++) begin
      set_group(pc, 3'b111);
      pc = pc + 32'd12;
      step();
      total_cnt++; if (count !== 4'd3) $display("FAIL wrap_count c%0d: got %0d expected 3", c, count); else pass_cnt++;
      total_cnt++; if (id_valid !== 3'b111) $display("FAIL wrap_id_valid c%0d: got %b expected 111", c, id_valid); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (id_pc[i] !== exp_pc + 32'(4 * i) || id_inst[i] !== (32'hA000_0000 | (exp_pc + 32'(4 * i))))
          $display("FAIL wrap_slot c%0d s%0d: got pc %h inst %h expected pc %h", c, i, id_pc[i], id_inst[i], exp_pc + 32'(4 * i));
        else pass_cnt++;
      end
      $display("wrap cycle %0d: id_pc=%h", c, id_pc);
      exp_pc = exp_pc + 32'd12;
    end
    if_valid = 3'b000;
    step();
    total_cnt++; if (count !== 4'd0) $display("FAIL wrap_drain_count: got %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_squash_gap_reset();
    rollback = 2'd3;
    set_group(32'h200, 3'b111);
    step();
    set_group(32'h20C, 3'b011);
    step();
    total_cnt++; if (count !== 4'd5) $display("FAIL sq_pre_count: got %0d expected 5", count); else pass_cnt++;
    squash   = 1'b1;
    rollback = 2'd0;
    set_group(32'h300, 3'b111);
    step();
    squash = 1'b0;
    total_cnt++; if (count !== 4'd0) $display("FAIL squash_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b000) $display("FAIL squash_id_valid: got %b expected 000", id_valid); else pass_cnt++;
    $display("squash: count=%0d id_valid=%b", count, id_valid);
    rollback = 2'd3;
    set_group(32'h400, 3'b101);
    step();
    if_valid = 3'b000;
    total_cnt++; if (count !== 4'd1) $display("FAIL gap_count: got %0d expected 1", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b001) $display("FAIL gap_id_valid: got %b expected 001", id_valid); else pass_cnt++;
    total_cnt++; if (id_pc[0] !== 32'h400) $display("FAIL gap_id_pc0: got %h expected 400", id_pc[0]); else pass_cnt++;
    $display("if_valid=101: count=%0d id_valid=%b", count, id_valid);
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (count !== 4'd0) $display("FAIL async_reset_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (id_valid !== 3'b000) $display("FAIL async_reset_id_valid: got %b expected 000", id_valid); else pass_cnt++;
    $display("mid-cycle reset: count=%0d id_valid=%b", count, id_valid);
    @(negedge clock);
    reset    = 1'b1;
    rollback = 2'd0;
    set_group(32'h500, 3'b111);
    step();
    if_valid = 3'b000;
    total_cnt++; if (count !== 4'd3) $display("FAIL post_reset_count: got %0d expected 3", count); else pass_cnt++;
    total_cnt++; if (id_pc[0] !== 32'h500) $display("FAIL post_reset_id_pc0: got %h expected 500", id_pc[0]); else pass_cnt++;
    $display("post-reset enqueue: count=%0d id_pc=%h", count, id_pc);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_partial_rollback();
    test_rollback_sat();
    test_wrap();
    test_squash_gap_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
